// File: rtl/dram_ctrl.sv
// Fast-RAM DRAM sequencer for 68EC020 cycles on the CD32 local bus:
// row/column muxing, RAS/CAS/WE strobes, DSACK termination and CBR refresh.
`timescale 1ns/1ps
module dram_ctrl #(
    parameter int unsigned REFRESH_PERIOD = 220,
    parameter int unsigned RAS_PRECHARGE  = 2,
    parameter int unsigned REF_HOLD       = 2
) (
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic       AS,
    input  logic       DS,
    input  logic       RW,
    input  logic [1:0] SIZ,
    input  logic [1:0] A,
    input  logic       RAM_SEL,
    output logic       RAM_MUX,
    output logic       RAS,
    output logic [3:0] CAS,
    output logic       WE,
    output logic [1:0] DSACK
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ROW     = 3'd1;
    localparam logic [2:0] ST_COL     = 3'd2;
    localparam logic [2:0] ST_CAS     = 3'd3;
    localparam logic [2:0] ST_REF_CAS = 3'd4;
    localparam logic [2:0] ST_REF_RAS = 3'd5;
    localparam logic [2:0] ST_PRE     = 3'd6;

    localparam logic [7:0] REF_RELOAD = 8'(REFRESH_PERIOD - 1);
    localparam logic [7:0] PRE_LOAD   = 8'(RAS_PRECHARGE - 1);
    // RAS only falls one cycle after REF_RAS is entered, so the state lasts one extra cycle
    localparam logic [7:0] HOLD_LOAD  = 8'(REF_HOLD);

    logic [2:0] st;
    logic [2:0] nxt;
    logic [7:0] ref_cnt;
    logic       ref_pend;
    logic [7:0] wcnt;
    logic       rw_lat;
    logic [3:0] lane;

    always_comb begin
        lane = '0;
        if (rw_lat) begin
            lane = '1;
        end else begin
            case (A)
                2'b00:   lane = {1'b1, SIZ != 2'b01, (SIZ == 2'b11) || (SIZ == 2'b00), SIZ == 2'b00};
                2'b01:   lane = {1'b0, 1'b1, SIZ != 2'b01, (SIZ == 2'b11) || (SIZ == 2'b00)};
                2'b10:   lane = {2'b00, 1'b1, SIZ != 2'b01};
                default: lane = 4'b0001;
            endcase
        end
    end

    always_comb begin
        nxt = st;
        case (st)
            ST_IDLE: begin
                if (ref_pend)
                    nxt = ST_REF_CAS;
                else if (!AS && RAM_SEL)
                    nxt = ST_ROW;
            end
            ST_ROW:     nxt = AS ? ST_PRE : ST_COL;
            ST_COL: begin
                if (AS)
                    nxt = ST_PRE;
                else if (rw_lat || !DS)
                    nxt = ST_CAS;
            end
            ST_CAS:     nxt = AS ? ST_PRE : ST_CAS;
            ST_REF_CAS: nxt = ST_REF_RAS;
            ST_REF_RAS: nxt = (wcnt == '0) ? ST_PRE : ST_REF_RAS;
            ST_PRE:     nxt = (wcnt == '0) ? ST_IDLE : ST_PRE;
            default:    nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            st     <= ST_IDLE;
            wcnt   <= '0;
            rw_lat <= 1'b1;
        end else begin
            st <= nxt;
            if (st == ST_IDLE && nxt == ST_ROW)
                rw_lat <= RW;
            if (nxt != st) begin
                if (nxt == ST_REF_RAS)
                    wcnt <= HOLD_LOAD;
                else if (nxt == ST_PRE)
                    wcnt <= PRE_LOAD;
            end else if (wcnt != '0) begin
                wcnt <= wcnt - 8'd1;
            end
        end
    end

    // an expiry that lands while a refresh is already pending is simply lost
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            ref_cnt  <= REF_RELOAD;
            ref_pend <= 1'b0;
        end else begin
            ref_cnt <= (ref_cnt == '0) ? REF_RELOAD : ref_cnt - 8'd1;
            if (ref_cnt == '0)
                ref_pend <= 1'b1;
            else if (st == ST_IDLE && ref_pend)
                ref_pend <= 1'b0;
        end
    end

    // Strobes follow the state one cycle behind, except that any move into PRE
    // releases everything on that same edge.
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            RAM_MUX <= 1'b1;
            RAS     <= 1'b1;
            CAS     <= '1;
            WE      <= 1'b1;
            DSACK   <= '1;
        end else begin
            RAM_MUX <= 1'b1;
            RAS     <= 1'b1;
            CAS     <= '1;
            WE      <= 1'b1;
            DSACK   <= '1;
            if (nxt != ST_PRE) begin
                case (st)
                    ST_ROW: begin
                        RAS <= 1'b0;
                        WE  <= rw_lat;
                    end
                    ST_COL: begin
                        RAS     <= 1'b0;
                        RAM_MUX <= 1'b0;
                        WE      <= rw_lat;
                    end
                    ST_CAS: begin
                        RAS     <= 1'b0;
                        RAM_MUX <= 1'b0;
                        WE      <= rw_lat;
                        CAS     <= ~lane;
                        DSACK   <= '0;
                    end
                    ST_REF_CAS: CAS <= '0;
                    ST_REF_RAS: begin
                        CAS <= '0;
                        RAS <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
